alu_seq_ctrl: RTL and testbench
===============================

Name: alu_seq_ctrl

Overview:
Multi-cycle sequencer that owns the single-cycle ALU (one-hot 12-bit op vector, bit0=ADD, bit1=SUB, ..., bit11=LUI) and exposes a valid/ready request/response interface to the core's execute stage. Plain ALU ops are passed through with one registered cycle of latency. MUL requests (low 32 bits of A*B) are executed as an iterative shift-add that reuses the ALU adder for one accumulate per cycle. Sits between the multi-cycle CPU control FSM and the ALU instance.

Parameters:
DATA_WIDTH, 32, operand/result width.
OP_WIDTH, 12, width of the one-hot ALU op vector.
CNT_WIDTH, 5, iteration counter width; must equal log2(DATA_WIDTH).

Ports:
clk  input  1  system clock, all state on rising edge.
rst  input  1  synchronous active-high reset.
req_valid  input  1  request present.
req_ready  output  1  block can accept a request.
req_mul  input  1  1 = MUL request; req_alu_op is ignored.
req_alu_op  input  OP_WIDTH  one-hot ALU op for pass-through requests.
req_a  input  DATA_WIDTH  operand A (multiplicand for MUL).
req_b  input  DATA_WIDTH  operand B (multiplier for MUL).
rsp_valid  output  1  result available.
rsp_ready  input  1  consumer accepts the result.
rsp_result  output  DATA_WIDTH  registered result.
rsp_zero  output  1  rsp_result == 0.
busy  output  1  state != IDLE.
alu_a  output  DATA_WIDTH  to ALU A.
alu_b  output  DATA_WIDTH  to ALU B.
alu_op  output  OP_WIDTH  to ALU alu_op.
alu_result  input  DATA_WIDTH  from ALU Result (combinational).

Behaviour:
- States: IDLE, EXEC, MUL, DONE.
- Reset: state=IDLE, rsp_valid=0, rsp_result=0, operand, accumulator and counter registers cleared. req_ready=0 while rst is high. Reset in any state aborts the operation and discards it.
- req_ready = (state==IDLE) & ~rst. No overlap: a new request is accepted only after the previous response has been consumed.
- IDLE: ALU outputs are driven to alu_a=0, alu_b=0, alu_op=0. On a handshake (req_valid & req_ready):
  - req_mul=0: latch a, b and op; go to EXEC.
  - req_mul=1: mcand<=req_a, mplier<=req_b, acc<=0, cnt<=0; go to MUL.
- EXEC (1 cycle): drive the latched a, b and op to the ALU. At the next edge: rsp_result<=alu_result, rsp_valid<=1, go to DONE. Response latency is 2 edges from the accepting edge. A zero or non-one-hot op is passed through unchecked.
- MUL: drive alu_a=acc, alu_b=mcand, alu_op=12'h001 (ADD). Each edge:
  - if mplier[0], acc<=alu_result;
  - mcand<=mcand<<1;
  - mplier<=mplier>>1 (logical);
  - cnt<=cnt+1.
  - When cnt==DATA_WIDTH-1 at the edge: rsp_result<=(mplier[0] ? alu_result : acc), rsp_valid<=1, go to DONE.
  - Exactly 32 MUL cycles. Result is modulo 2^32 and identical for signed and unsigned operands.
- DONE: rsp_valid=1 and rsp_result is held stable until rsp_ready. On (rsp_valid & rsp_ready): rsp_valid<=0, go to IDLE. rsp_ready while not valid has no effect.
- rsp_zero is combinational from rsp_result and is valid only while rsp_valid is high.
- busy=1 in EXEC, MUL and DONE.

Optional Feature:
Macro MUL_EARLY_TERM_EN.
- Defined: in MUL, if the next mplier value (mplier>>1) is 0, or cnt==DATA_WIDTH-1, then at that edge capture the result as above and go to DONE. MUL lasts (index of the highest set bit of B)+1 cycles, minimum 1; B=0 gives 1 cycle with result 0.
- Undefined: MUL always lasts 32 cycles.
- Results are identical in both builds; only latency differs.

Test Plan:
- Reset: hold rst 2 cycles -> rsp_valid=0, rsp_result=0, busy=0, req_ready=0 during rst and 1 after release.
- ADD 5+7 (op=12'h001), rsp_ready=1 -> rsp_valid 2 edges after accept, rsp_result=12, rsp_zero=0, back to IDLE the next edge.
- SUB 3-3 (op=12'h002) with rsp_ready held low 5 cycles -> rsp_valid and result 0 held stable, rsp_zero=1, req_ready=0 throughout.
- MUL 6*7 and 0xFFFFFFFF*0xFFFFFFFF -> 42 and 0x00000001. Without the macro, rsp_valid rises exactly 33 edges after accept; alu_op=12'h001 for all MUL cycles.
- Reset asserted mid-MUL (cnt=10) -> next edge: IDLE, rsp_valid=0; no response emitted. A following ADD 1+1 returns 2.
- With MUL_EARLY_TERM_EN: 0x1234*1 -> 0x1234 after 1 MUL cycle; 9*0 -> 0 after 1 MUL cycle; 3*0x80000000 -> 0x80000000 after 32 MUL cycles.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: request/response sequencer in front of a single-cycle one-hot ALU.
// Plain ops go through the ALU with one registered cycle of latency. MUL is an
// iterative shift-add that borrows the ALU adder for one accumulate per cycle.
// Optional build macro: MUL_EARLY_TERM_EN -- MUL stops as soon as the remaining
// multiplier bits are all zero (results are unchanged, only latency shrinks).
module alu_seq_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 12,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_mul,
    input  logic [OP_WIDTH-1:0]   req_alu_op,
    input  logic [DATA_WIDTH-1:0] req_a,
    input  logic [DATA_WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_result,
    output logic                  rsp_zero,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [OP_WIDTH-1:0]   alu_op,
    input  logic [DATA_WIDTH-1:0] alu_result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [OP_WIDTH-1:0]  OP_ADD   = OP_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

    state_t state;
    state_t state_nxt;

    // opa/opb hold the pass-through operands, and double as multiplicand /
    // multiplier during MUL (they are never needed at the same time).
    logic [DATA_WIDTH-1:0] opa;
    logic [DATA_WIDTH-1:0] opb;
    logic [OP_WIDTH-1:0]   op_q;
    logic [DATA_WIDTH-1:0] acc;
    logic [CNT_WIDTH-1:0]  cnt;

    logic accept;
    logic rsp_fire;
    logic mul_last;

    assign accept   = req_valid & req_ready;
    assign rsp_fire = rsp_valid & rsp_ready;

    // Handshake and status outputs; ready is masked by reset so nothing is taken during it.
    always_comb begin
        req_ready = (state == IDLE) & ~rst;
        busy      = (state != IDLE);
        rsp_zero  = (rsp_result == '0);
    end

`ifdef MUL_EARLY_TERM_EN
    // Stop once no multiplier bits remain, or after the final bit position.
    always_comb begin
        mul_last = (cnt == CNT_LAST) || ((opb >> 1) == '0);
    end
`else
    // Fixed-length multiply: always walk every multiplier bit.
    always_comb begin
        mul_last = (cnt == CNT_LAST);
    end
`endif

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = req_mul ? MUL : EXEC;
                end
            end
            EXEC: state_nxt = DONE;
            MUL: begin
                if (mul_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (rsp_fire) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ALU drive: idle is quiet, EXEC replays the latched op, MUL uses the adder on acc + mcand.
    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = '0;
        case (state)
            EXEC: begin
                alu_a  = opa;
                alu_b  = opb;
                alu_op = op_q;
            end
            MUL: begin
                alu_a  = acc;
                alu_b  = opa;
                alu_op = OP_ADD;
            end
            default: ;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath: operand capture, shift-add iteration and response register.
    always_ff @(posedge clk) begin
        if (rst) begin
            opa        <= '0;
            opb        <= '0;
            op_q       <= '0;
            acc        <= '0;
            cnt        <= '0;
            rsp_result <= '0;
            rsp_valid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        opa <= req_a;
                        opb <= req_b;
                        if (req_mul) begin
                            acc <= '0;
                            cnt <= '0;
                        end else begin
                            op_q <= req_alu_op;
                        end
                    end
                end
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_valid  <= 1'b1;
                end
                MUL: begin
                    if (opb[0]) begin
                        acc <= alu_result;
                    end
                    opa <= opa << 1;
                    opb <= opb >> 1;
                    cnt <= cnt + 1'b1;
                    if (mul_last) begin
                        // Final partial product is folded in here rather than a cycle later.
                        rsp_result <= opb[0] ? alu_result : acc;
                        rsp_valid  <= 1'b1;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: supplies a behavioural ALU, runs directed cases with
// literal expectations, then randomized traffic checked every cycle against a
// transaction-level model (result = op(a,b) or a*b, known latency, handshake rules).
module tb_alu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_mul = 1'b0;
    logic [11:0] req_alu_op = '0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic        busy;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [11:0] alu_op;
    logic [31:0] alu_result;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_cyc = 0;
    bit chk_en = 1'b0;
    bit rand_rdy = 1'b0;

    alu_seq_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_mul(req_mul),
        .req_alu_op(req_alu_op), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_zero(rsp_zero), .busy(busy),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU; non-one-hot ops get an arbitrary but deterministic value.
    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [11:0] op);
        case (op)
            12'h001: return a + b;
            12'h002: return a - b;
            12'h004: return a & b;
            12'h008: return a | b;
            12'h010: return a ^ b;
            12'h020: return a << b[4:0];
            12'h040: return a >> b[4:0];
            12'h080: return $unsigned($signed(a) >>> b[4:0]);
            12'h100: return {31'b0, $signed(a) < $signed(b)};
            12'h200: return {31'b0, a < b};
            12'h400: return ~(a | b);
            12'h800: return {b[19:0], 12'b0};
            default: return a ^ {b[15:0], b[31:16]} ^ {20'b0, op};
        endcase
    endfunction

    always_comb alu_result = alu_fn(alu_a, alu_b, alu_op);

    // Edges from the accepting edge (excluded) to the edge that raises rsp_valid.
    function automatic int mul_cycles(input logic [31:0] b);
`ifdef MUL_EARLY_TERM_EN
        int hi = 0;
        for (int i = 0; i < 32; i++) if (b[i]) hi = i;
        return hi + 1;
`else
        return 32;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction-level reference model.
    bit          m_busy = 0, m_valid = 0, m_mul = 0;
    logic [31:0] m_a = '0, m_b = '0, m_res = '0, m_pend = '0;
    logic [11:0] m_op = '0;
    int          m_left = 0;

    // Model advances on the same edges the DUT sees, from inputs only.
    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 0; m_valid <= 0; m_res <= '0;
        end else if (!m_busy) begin
            if (req_valid) begin
                m_busy <= 1; m_mul <= req_mul;
                m_a <= req_a; m_b <= req_b; m_op <= req_alu_op;
                m_pend <= req_mul ? req_a * req_b : alu_fn(req_a, req_b, req_alu_op);
                m_left <= req_mul ? mul_cycles(req_b) : 1;
            end
        end else if (!m_valid) begin
            if (m_left == 1) begin
                m_valid <= 1; m_res <= m_pend;
            end else begin
                m_left <= m_left - 1;
            end
        end else if (rsp_ready) begin
            m_valid <= 0; m_busy <= 0;
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", {31'b0, req_ready}, {31'b0, !m_busy && !rst});
            chk("busy", {31'b0, busy}, {31'b0, m_busy});
            chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, m_valid});
            chk("rsp_result", rsp_result, m_res);
            if (m_valid) chk("rsp_zero", {31'b0, rsp_zero}, {31'b0, m_res == 0});
            if (!m_busy) begin
                chk("idle_alu_a", alu_a, 32'h0);
                chk("idle_alu_b", alu_b, 32'h0);
                chk("idle_alu_op", {20'b0, alu_op}, 32'h0);
            end else if (!m_valid && !m_mul) begin
                chk("exec_alu_a", alu_a, m_a);
                chk("exec_alu_b", alu_b, m_b);
                chk("exec_alu_op", {20'b0, alu_op}, {20'b0, m_op});
            end else if (!m_valid && m_mul) begin
                chk("mul_alu_op", {20'b0, alu_op}, 32'h1);
            end
        end
    end

    // Random consumer backpressure during the random phase.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rand_rdy) rsp_ready = 1'($urandom % 2);
        end
    end

    // Wait for the model to go idle, present one request, and return just after the accepting edge.
    task automatic issue(input bit mul, input logic [11:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        int k = 0;
        @(posedge clk); #1;
        while (m_busy && k < 300) begin
            @(posedge clk); #1; k++;
        end
        if (k >= 300) chk("issue_timeout", 32'd1, 32'd0);
        req_mul = mul; req_alu_op = op; req_a = a; req_b = b; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_mul = 1'($urandom); req_alu_op = 12'($urandom);
        req_a = $urandom; req_b = $urandom;
        acc_cyc = cyc;
    endtask

    // Wait (bounded) for rsp_valid; check result and latency counted with the accept edge as edge 1.
    task automatic wait_rsp(input string name, input logic [31:0] exp, input int lat);
        bit got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1;
                chk({name, "_result"}, rsp_result, exp);
                chk({name, "_latency"}, cyc - acc_cyc + 1, lat);
            end
        end
        if (!got) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        int seen;
        // Reset held for two edges.
        rst = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rsp_result", rsp_result, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_req_ready", {31'b0, req_ready}, 32'd1);

        // ADD 5+7, consumer always ready.
        rsp_ready = 1'b1;
        issue(0, 12'h001, 32'd5, 32'd7);
        wait_rsp("add", 32'd12, 2);
        chk("add_zero", {31'b0, rsp_zero}, 32'd0);
        @(posedge clk); #1;
        chk("add_back_idle", {31'b0, busy}, 32'd0);

        // SUB 3-3 with the consumer stalled for 5 cycles.
        rsp_ready = 1'b0;
        issue(0, 12'h002, 32'd3, 32'd3);
        wait_rsp("sub", 32'd0, 2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("sub_hold_valid", {31'b0, rsp_valid}, 32'd1);
            chk("sub_hold_result", rsp_result, 32'd0);
            chk("sub_hold_zero", {31'b0, rsp_zero}, 32'd1);
            chk("sub_hold_ready", {31'b0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;

        // Multiplies.
        issue(1, 12'h000, 32'd6, 32'd7);
        wait_rsp("mul_6x7", 32'd42, mul_cycles(32'd7) + 1);
        issue(1, 12'h000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_rsp("mul_ffxff", 32'h0000_0001, 33);

        // Abort a MUL at cnt=10 with a reset; no response may follow.
        issue(1, 12'h000, 32'd5, 32'hF000_0001);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_valid", {31'b0, rsp_valid}, 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("abort_no_rsp", seen, 32'd0);
        issue(0, 12'h001, 32'd1, 32'd1);
        wait_rsp("add_after_abort", 32'd2, 2);

        // Early-termination boundary cases (full length without the macro).
`ifdef MUL_EARLY_TERM_EN
        issue(1, 12'h000, 32'h1234, 32'd1);
        wait_rsp("mul_x1", 32'h1234, 2);
        issue(1, 12'h000, 32'd9, 32'd0);
        wait_rsp("mul_x0", 32'd0, 2);
`else
        issue(1, 12'h000, 32'h1234, 32'd1);
        wait_rsp("mul_x1", 32'h1234, 33);
        issue(1, 12'h000, 32'd9, 32'd0);
        wait_rsp("mul_x0", 32'd0, 33);
`endif
        issue(1, 12'h000, 32'd3, 32'h8000_0000);
        wait_rsp("mul_msb", 32'h8000_0000, 33);

        // Randomized traffic with backpressure and occasional aborts.
        rand_rdy = 1'b1;
        for (int t = 0; t < 150; t++) begin
            bit          mul;
            logic [11:0] op;
            logic [31:0] b;
            int          k;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            mul = ($urandom % 3) == 0;
            op  = ($urandom % 8 == 0) ? 12'($urandom) : (12'h1 << $urandom_range(0, 11));
            b   = ($urandom % 2) ? ($urandom >> $urandom_range(0, 31)) : $urandom;
            issue(mul, op, $urandom, b);
            if ($urandom % 20 == 0) begin
                repeat ($urandom_range(0, 35)) @(posedge clk);
                #1 rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
            end else begin
                k = 0;
                while (m_busy && k < 300) begin
                    @(posedge clk); #1; k++;
                end
                if (k >= 300) chk("rand_drain_timeout", 32'd1, 32'd0);
            end
        end
        rand_rdy = 1'b0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
